// File: rtl/kpg_pkg.sv
// Shared KPG symbol encoding and prefix combine operator for the
// Kogge-Stone adder pipeline.
package kpg_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_K = 2'b00;
  localparam kpg_t KPG_P = 2'b01;
  localparam kpg_t KPG_G = 2'b10;

  // hi is the more-significant span; a propagating hi defers to lo.
  function automatic kpg_t kpg_combine(input kpg_t lo, input kpg_t hi);
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/kpg_cell.sv
// One Kogge-Stone prefix node: combinational KPG combine.
module kpg_cell
  import kpg_pkg::*;
(
  input  logic [1:0] lo,
  input  logic [1:0] hi,
  output logic [1:0] y
);

  assign y = kpg_combine(lo, hi);

endmodule

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone KPG prefix adder, one prefix level per stage,
// valid/ready on both sides. Optional ovf port under `KPG_OVF_EN.
module kpg_prefix_adder_pipe
  import kpg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KPG_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LVL = $clog2(WIDTH);

  // Symbol index 0 is the cin symbol (bit -1); index i+1 is operand bit i.
  kpg_t [WIDTH:0]   enc;
  kpg_t [WIDTH:0]   sym_q [LVL+1];
  kpg_t [WIDTH:0]   lvl_d [1:LVL];
  logic [WIDTH-1:0] p_q   [LVL+1];
  logic [LVL:0]     v_q;
  logic [WIDTH:0]   carry;
  logic             adv;

  assign out_valid = v_q[LVL];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  always_comb begin
    enc    = '0;
    enc[0] = cin ? KPG_G : KPG_K;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      enc[i+1] = (a[i] & b[i]) ? KPG_G : ((a[i] ^ b[i]) ? KPG_P : KPG_K);
    end
  end

  genvar j, k;
  generate
    for (j = 1; j <= LVL; j++) begin : g_lvl
      localparam int D = 1 << (j - 1);
      for (k = 0; k <= WIDTH; k++) begin : g_node
        if (k >= D) begin : g_cell
          kpg_cell u_cell (
            .lo (sym_q[j-1][k-D]),
            .hi (sym_q[j-1][k]),
            .y  (lvl_d[j][k])
          );
        end else begin : g_pass
          assign lvl_d[j][k] = sym_q[j-1][k];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned s = 0; s <= LVL; s++) begin
        sym_q[s] <= '0;
        p_q[s]   <= '0;
      end
    end else if (adv) begin
      v_q[0]   <= in_valid;
      sym_q[0] <= enc;
      p_q[0]   <= a ^ b;
      for (int unsigned s = 1; s <= LVL; s++) begin
        v_q[s]   <= v_q[s-1];
        sym_q[s] <= lvl_d[s];
        p_q[s]   <= p_q[s-1];
      end
    end
  end

  // LVL levels of doubling span WIDTH symbols, so the top node stops one
  // short of the cin symbol; a residual P there resolves to the cin symbol.
  always_comb begin
    carry = '0;
    for (int unsigned n = 0; n <= WIDTH; n++) begin
      carry[n] = (sym_q[LVL][n] == KPG_G) ||
                 ((sym_q[LVL][n] == KPG_P) && (sym_q[LVL][0] == KPG_G));
    end
  end

  assign sum  = p_q[LVL] ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

`ifdef KPG_OVF_EN
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];
`endif

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// Scoreboard bench for kpg_prefix_adder_pipe (WIDTH=16, latency 5);
// checks ovf when built with KPG_OVF_EN.
module tb_kpg_prefix_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  kpg_prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef KPG_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef KPG_OVF_EN
  assign ovf = 1'b0;
`endif

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    exp_t       e;
    r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s = r[W-1:0];
    e.c = r[W];
    e.o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake happens on the next rising edge when both are high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got sum %h cout %b expected no output at %0t", sum, cout, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", {16'h0, sum}, {16'h0, e.s});
        chk("cout", {31'h0, cout}, {31'h0, e.c});
`ifdef KPG_OVF_EN
        chk("ovf", {31'h0, ovf}, {31'h0, e.o});
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("drain_timeout", q.size(), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum", {16'h0, sum}, 32'h0);
    chk("rst_cout", {31'h0, cout}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // 2: full-width carry ripple, with latency check
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("latency_out_valid", {31'h0, out_valid}, (n == 4) ? 32'h1 : 32'h0);
    end
    if (out_valid) begin
      chk("ripple_sum", {16'h0, sum}, 32'h0000);
      chk("ripple_cout", {31'h0, cout}, 32'h1);
    end
    drain();

    // 3: cin through all levels
    send(16'hFFFF, 16'h0000, 1'b1);
    drain();

    // 4: back-to-back stream
    send(16'h1234, 16'h4321, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0);
    drain();

    // 5: output stall holds result and blocks input
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h0F0F, 16'hF0F1, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_reached", {31'h0, out_valid}, 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_sum", {16'h0, sum}, 32'h3333);
      chk("stall_cout", {31'h0, cout}, 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("post_stall_idle", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // 6: signed overflow case, then reset with ops in flight
    send(16'h7FFF, 16'h0001, 1'b0);
    drain();
    send(16'h0001, 16'h0002, 1'b0);
    send(16'h0003, 16'h0004, 1'b0);
    send(16'h0005, 16'h0006, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_sum", {16'h0, sum}, 32'h0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("midrst_no_output", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // random stream with random back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = W'($urandom_range(32'hFFFF));
      b         = W'($urandom_range(32'hFFFF));
      cin       = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      chk("in_ready_rule", {31'h0, in_ready}, {31'h0, (~out_valid | out_ready)});
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_ops_issued", sent, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
